// File: rtl/sd_cmd_responder.sv
// sd_cmd_responder: card-side SD CMD line engine; receives CRC7-checked host commands and sends NCR-gapped responses.
// Define SD_CMD_STATS_EN to build the saturating command / CRC-error counters.
module sd_cmd_responder #(
  parameter int NCR = 2,
  parameter int RESP_TIMEOUT = 64
) (
  input  logic        iclk,
  input  logic        irst,
  input  logic        icmd_sd,
  output logic        ocmd_sd,
  output logic        ocmd_sd_en,
  output logic        ocmd_valid,
  output logic [5:0]  ocmd_index,
  output logic [31:0] ocmd_arg,
  input  logic        iresp_valid,
  input  logic [1:0]  iresp_type,
  input  logic [31:0] iresp_data,
  output logic        obusy,
  output logic        ocrc_err,
  output logic        otimeout,
  output logic [15:0] ocmd_count,
  output logic [15:0] ocrc_err_count
);
  localparam int WW = $clog2(RESP_TIMEOUT + 1);
  localparam logic [WW-1:0] W_GO = WW'(NCR - 1);
  localparam logic [WW-1:0] W_TO = WW'(RESP_TIMEOUT - 1);
  typedef enum logic [1:0] {IDLE, RX, WAIT, TX} state_t;
  state_t state;
  logic [5:0] cnt;
  logic [44:0] rx_sr;
  logic [6:0] crc;
  logic [WW-1:0] w;
  logic pending;
  logic [47:0] tx_sr;
  logic resp_none;
  logic resp_r3;
  logic crc_ok;
  logic tx_go;
  logic [47:0] resp_frame;
  logic [47:0] tx_src;
  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    return {c[5:0], 1'b0} ^ ((b ^ c[6]) ? 7'h09 : 7'h00);
  endfunction
  function automatic logic [6:0] crc7_40(input logic [39:0] m);
    logic [6:0] c;
    c = '0;
    for (int i = 39; i >= 0; i--) c = crc7_step(c, m[i]);
    return c;
  endfunction
  assign resp_none = iresp_type[1] == iresp_type[0];
  assign resp_r3 = iresp_type == 2'b10;
  assign resp_frame = {2'b00, resp_r3 ? 6'h3f : ocmd_index, iresp_data,
                       resp_r3 ? 7'h7f : crc7_40({2'b00, ocmd_index, iresp_data}), 1'b1};
  assign crc_ok = rx_sr[6:0] == crc && icmd_sd;
  assign tx_src = pending ? tx_sr : resp_frame;
  // an early offer is parked until the NCR gap has elapsed
  assign tx_go = state == WAIT && (pending ? w == W_GO : iresp_valid && !resp_none && w >= W_GO);
  assign obusy = state != IDLE;
  always_ff @(posedge iclk or negedge irst) begin
    if (!irst) begin
      state <= IDLE;
      cnt <= '0;
      rx_sr <= '0;
      crc <= '0;
      w <= '0;
      pending <= 1'b0;
      tx_sr <= '1;
      ocmd_sd <= 1'b1;
      ocmd_sd_en <= 1'b0;
      ocmd_valid <= 1'b0;
      ocrc_err <= 1'b0;
      otimeout <= 1'b0;
      ocmd_index <= '0;
      ocmd_arg <= '0;
    end else begin
      ocmd_valid <= 1'b0;
      ocrc_err <= 1'b0;
      otimeout <= 1'b0;
      case (state)
        IDLE: if (!icmd_sd) begin
          state <= RX;
          cnt <= 6'd1;
          crc <= '0;
        end
        RX: begin
          rx_sr <= {rx_sr[43:0], icmd_sd};
          cnt <= cnt + 6'd1;
          if (cnt <= 6'd39) crc <= crc7_step(crc, icmd_sd);
          if (cnt == 6'd1 && !icmd_sd) state <= IDLE;
          else if (cnt == 6'd47) begin
            if (crc_ok) begin
              ocmd_valid <= 1'b1;
              ocmd_index <= rx_sr[44:39];
              ocmd_arg <= rx_sr[38:7];
              state <= WAIT;
              w <= {{(WW-1){1'b0}}, 1'b1};
              pending <= 1'b0;
            end else begin
              ocrc_err <= 1'b1;
              state <= IDLE;
            end
          end
        end
        WAIT: begin
          w <= w + 1'b1;
          if (tx_go) begin
            state <= TX;
            ocmd_sd_en <= 1'b1;
            ocmd_sd <= tx_src[47];
            tx_sr <= {tx_src[46:0], 1'b1};
            cnt <= 6'd1;
            pending <= 1'b0;
          end else if (!pending) begin
            if (iresp_valid) begin
              if (resp_none) state <= IDLE;
              else begin
                pending <= 1'b1;
                tx_sr <= resp_frame;
              end
            end else if (w == W_TO) begin
              otimeout <= 1'b1;
              state <= IDLE;
            end
          end
        end
        TX: if (cnt == 6'd48) begin
          ocmd_sd_en <= 1'b0;
          ocmd_sd <= 1'b1;
          state <= IDLE;
        end else begin
          ocmd_sd <= tx_sr[47];
          tx_sr <= {tx_sr[46:0], 1'b1};
          cnt <= cnt + 6'd1;
        end
      endcase
    end
  end
`ifdef SD_CMD_STATS_EN
  always_ff @(posedge iclk or negedge irst) begin
    if (!irst) begin
      ocmd_count <= '0;
      ocrc_err_count <= '0;
    end else begin
      if (ocmd_valid && ocmd_count != 16'hffff) ocmd_count <= ocmd_count + 16'd1;
      if (ocrc_err && ocrc_err_count != 16'hffff) ocrc_err_count <= ocrc_err_count + 16'd1;
    end
  end
`else
  assign ocmd_count = '0;
  assign ocrc_err_count = '0;
`endif
endmodule

// File: tb/tb_sd_cmd_responder.sv
// tb_sd_cmd_responder: directed and randomized host command frames against a frame-level reference model.
module tb_sd_cmd_responder;
  localparam int NCR = 2;
  localparam int RT = 64;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic icmd_sd = 1'b1;
  logic iresp_valid = 1'b0;
  logic [1:0] iresp_type = '0;
  logic [31:0] iresp_data = '0;
  logic ocmd_sd, ocmd_sd_en, ocmd_valid, obusy, ocrc_err, otimeout;
  logic [5:0] ocmd_index;
  logic [31:0] ocmd_arg;
  logic [15:0] ocmd_count, ocrc_err_count;
  int n_cmp = 0;
  int n_bad = 0;
  int exp_cmds = 0;
  int exp_errs = 0;
  always #5 clk = ~clk;
  sd_cmd_responder #(.NCR(NCR), .RESP_TIMEOUT(RT)) dut (
    .iclk(clk), .irst(rst_n), .icmd_sd(icmd_sd), .ocmd_sd(ocmd_sd), .ocmd_sd_en(ocmd_sd_en),
    .ocmd_valid(ocmd_valid), .ocmd_index(ocmd_index), .ocmd_arg(ocmd_arg),
    .iresp_valid(iresp_valid), .iresp_type(iresp_type), .iresp_data(iresp_data),
    .obusy(obusy), .ocrc_err(ocrc_err), .otimeout(otimeout),
    .ocmd_count(ocmd_count), .ocrc_err_count(ocrc_err_count)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // CRC7 as the remainder of m(x)*x^7 divided by x^7+x^3+1
  function automatic logic [6:0] crc7_ref(input logic [39:0] m);
    logic [46:0] r;
    r = {m, 7'b0};
    for (int i = 46; i >= 7; i--) if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    return r[6:0];
  endfunction
  function automatic logic [47:0] cmd_frame(input logic [5:0] idx, input logic [31:0] arg);
    return {2'b01, idx, arg, crc7_ref({2'b01, idx, arg}), 1'b1};
  endfunction
  function automatic logic [47:0] resp_line(input logic [5:0] idx, input logic [1:0] rt, input logic [31:0] data);
    logic [39:0] head;
    head = {2'b00, rt == 2'b10 ? 6'h3f : idx, data};
    return {head, rt == 2'b10 ? 7'h7f : crc7_ref(head), 1'b1};
  endfunction
  task automatic send(input logic [47:0] f, input bit now);
    for (int i = 47; i >= 0; i--) begin
      if (!(now && i == 47)) @(negedge clk);
      if (i == 46) check("busy_rise", obusy, 1'b1);
      icmd_sd = f[i];
    end
  endtask
  // sends one frame, offers a response in cycle E+d (d=0: never), checks the whole exchange
  task automatic txn(input logic [47:0] f, input int d, input logic [1:0] rt, input logic [31:0] rd,
                     input logic [47:0] exp_line, input bit b2b);
    logic ok, none, seen;
    int first, nbits, end_j, to_j, j0, exp_end;
    logic [47:0] line;
    ok = (f[7:1] == crc7_ref(f[47:8])) && f[0];
    none = (rt == 2'b00) || (rt == 2'b11);
    first = 0; nbits = 0; end_j = 0; to_j = 0; j0 = 0; line = '0;
    send(f, b2b);
    for (int j = 1; j <= RT + 60; j++) begin
      @(negedge clk);
      icmd_sd = 1'b1;
      if (j == 1) begin
        check("valid", ocmd_valid, ok);
        check("crc_err", ocrc_err, !ok);
        if (ok) begin
          check("index", ocmd_index, f[45:40]);
          check("arg", ocmd_arg, f[39:8]);
        end
      end
      iresp_valid = (j == d);
      iresp_type = rt;
      iresp_data = rd;
      if (ocmd_sd_en) begin
        if (first == 0) first = j;
        line = {line[46:0], ocmd_sd};
        nbits++;
      end
      if (otimeout && to_j == 0) to_j = j;
      if (!obusy) begin
        end_j = j;
        break;
      end
    end
    iresp_valid = 1'b0;
    exp_cmds += ok;
    exp_errs += !ok;
    if (!ok) exp_end = 1;
    else if (d == 0) exp_end = RT;
    else if (none) exp_end = d + 1;
    else begin
      j0 = (d + 1 > NCR) ? d + 1 : NCR;
      exp_end = j0 + 48;
    end
    check("end_cycle", end_j, exp_end);
    check("timeout_cycle", to_j, (ok && d == 0) ? RT : 0);
    if (ok && d != 0 && !none) begin
      check("start_cycle", first, j0);
      check("nbits", nbits, 48);
      check("line", line, exp_line);
      check("idle_level", ocmd_sd, 1'b1);
    end else check("no_drive", nbits, 0);
    if (ok && d == 0) begin
      @(negedge clk);
      iresp_valid = 1'b1;
      iresp_type = 2'b01;
      seen = 1'b0;
      repeat (4) begin
        @(negedge clk);
        iresp_valid = 1'b0;
        seen = seen | ocmd_sd_en | obusy;
      end
      check("late_offer", seen, 1'b0);
    end
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [5:0] idx;
    logic [31:0] arg, rd;
    logic [47:0] f;
    logic [1:0] rt;
    logic seen;
    int d, r;
    bit b2b;
    repeat (3) @(negedge clk);
    check("rst_sd", ocmd_sd, 1'b1);
    check("rst_en", ocmd_sd_en, 1'b0);
    check("rst_valid", ocmd_valid, 1'b0);
    check("rst_busy", obusy, 1'b0);
    check("rst_pulses", {ocrc_err, otimeout}, 2'b00);
    check("rst_index_arg", {ocmd_index, ocmd_arg}, 38'h0);
    check("rst_counts", {ocmd_count, ocrc_err_count}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    txn(48'h400000000095, 1, 2'b00, 32'h0, 48'h0, 1'b0);
    txn(48'h48000001AA87, 1, 2'b01, 32'h000001AA, 48'h08000001AA13, 1'b0);
    txn(cmd_frame(6'd41, 32'h40FF8000), 3, 2'b10, 32'h00FF8000, 48'h3F00FF8000FF, 1'b0);
    txn(48'h770000000067, 1, 2'b01, 32'h0, 48'h0, 1'b1);
    txn(48'h400000000095, 0, 2'b01, 32'h0, 48'h0, 1'b1);
    @(negedge clk); icmd_sd = 1'b0;
    @(negedge clk); icmd_sd = 1'b0;
    @(negedge clk); icmd_sd = 1'b1;
    seen = obusy;
    repeat (50) begin
      @(negedge clk);
      seen = seen | obusy | ocmd_valid | ocrc_err;
    end
    check("not_host_frame", seen, 1'b0);
    send(48'h48000001AA87, 1'b0);
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      icmd_sd = 1'b1;
      iresp_valid = (j == 1);
      iresp_type = 2'b01;
      iresp_data = 32'h1AA;
    end
    iresp_valid = 1'b0;
    check("pre_rst_en", ocmd_sd_en, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_en", ocmd_sd_en, 1'b0);
    check("async_rst_sd", ocmd_sd, 1'b1);
    check("async_rst_busy", obusy, 1'b0);
    check("async_rst_index", ocmd_index, 6'd0);
    exp_cmds = 0;
    exp_errs = 0;
    @(negedge clk);
    rst_n = 1'b1;
    txn(48'h400000000095, 1, 2'b00, 32'h0, 48'h0, 1'b0);
    for (int k = 0; k < 30; k++) begin
      idx = 6'($urandom_range(0, 63));
      arg = $urandom;
      rd = $urandom;
      rt = 2'($urandom_range(0, 3));
      f = cmd_frame(idx, arg);
      if ($urandom_range(0, 4) == 0) begin
        r = $urandom_range(0, 7);
        f[r] = ~f[r];
      end
      r = $urandom_range(0, 9);
      d = (r == 0) ? 0 : $urandom_range(1, r < 7 ? 3 : RT - 1);
      b2b = 1'($urandom_range(0, 1));
      if (!b2b) repeat ($urandom_range(1, 3)) @(negedge clk);
      txn(f, d, rt, rd, resp_line(idx, rt, rd), b2b);
    end
    @(negedge clk);
`ifdef SD_CMD_STATS_EN
    check("cmd_count", ocmd_count, exp_cmds);
    check("err_count", ocrc_err_count, exp_errs);
`else
    check("cmd_count_off", ocmd_count, 16'h0);
    check("err_count_off", ocrc_err_count, 16'h0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sd_cmd_responder.md
Name: sd_cmd_responder

Overview:
- Card-side CMD line engine: the responder end of the SD bus command protocol issued by the host controller.
- Deserialises 48-bit host command frames from the CMD line and checks their CRC7.
- Hands each valid command to card-emulation logic, then serialises the 48-bit response that logic supplies, after the spec-mandated NCR gap.
- Used in the card emulator and as a synthesizable bus model in host-side benches.

Parameters:
- NCR, 2, cycles from command end bit to response start bit (minimum gap); legal 2..64.
- RESP_TIMEOUT, 64, cycles after command end bit within which iresp_valid must arrive; must be >= NCR.

Ports:
- iclk  in  1  SD clock; CMD sampled and driven on rising edge.
- irst  in  1  asynchronous, active-low reset.
- icmd_sd  in  1  CMD line input.
- ocmd_sd  out  1  CMD line output value.
- ocmd_sd_en  out  1  CMD line output enable.
- ocmd_valid  out  1  one-cycle pulse: valid command received.
- ocmd_index  out  6  command index, stable from ocmd_valid until next frame.
- ocmd_arg  out  32  command argument, same stability.
- iresp_valid  in  1  response offer, sampled only in WAIT.
- iresp_type  in  2  00 none, 01 R1-format (echo index + CRC7), 10 R3-format (index and CRC fields all ones), 11 treated as 00.
- iresp_data  in  32  response payload.
- obusy  out  1  high outside IDLE.
- ocrc_err  out  1  one-cycle pulse: CRC or end-bit error.
- otimeout  out  1  one-cycle pulse: no response offered in time.
- ocmd_count  out  16  received-command counter (optional feature).
- ocrc_err_count  out  16  CRC-error counter (optional feature).

Behaviour:
- Reset values: ocmd_sd=1, ocmd_sd_en=0, all pulses/obusy=0, index/arg/counters=0, state IDLE. Async reset mid-frame forces ocmd_sd_en=0 immediately.
- IDLE: icmd_sd=0 sampled → RX, bit counter=1. obusy rises the cycle after.
- RX: shift 48 bits MSB first; CRC7 (x^7+x^3+1, init 0) over bits 47..8.
  - Bit 46 (transmission bit) = 0 → frame is not a host command; return to IDLE, no pulses.
- End of RX (cycle E = end bit sampled):
  - Received CRC == computed and end bit = 1 → latch index/arg, pulse ocmd_valid at E+1, go to WAIT.
  - Otherwise → pulse ocrc_err at E+1, return to IDLE.
- WAIT: cycle counter starts at E.
  - iresp_valid=1 at cycle A → capture type/data.
  - Type none → IDLE at A+1.
  - Else → TX with first start bit driven at cycle max(E+NCR, A+1).
  - No offer by E+RESP_TIMEOUT → pulse otimeout, IDLE.
  - iresp_valid is ignored in every state except WAIT.
- TX: ocmd_sd_en=1; frame bits: start 0, transmission 0, 6-bit index (R1 echo / 111111 for R3), 32-bit data, CRC7 (R1 computed over first 40 bits / 1111111 for R3), end 1.
  - The cycle after the end bit: ocmd_sd_en=0, ocmd_sd=1, state IDLE.
  - icmd_sd is ignored throughout TX and WAIT.
- Back-to-back: a start bit seen the first cycle in IDLE after TX or an error is accepted.

Optional Feature:
- Macro SD_CMD_STATS_EN.
- Defined: ocmd_count increments on each ocmd_valid, ocrc_err_count on each ocrc_err; both saturate at 0xFFFF and clear only on reset.
- Undefined: both ports are constant 0 and no counter logic is built.

Test Plan:
- CMD0 frame 0x400000000095 → ocmd_valid, index 0, arg 0; respond type 00 → no CMD drive, obusy falls, IDLE.
- CMD8 0x48000001AA87 → index 8, arg 0x000001AA; respond R1 data 0x000001AA at E+1 → line carries 0x08000001AA13 starting exactly E+2 (NCR=2), en drops after end bit.
- CMD41 0x6940FF8000xx with correct CRC; R3 data 0x00FF8000 → line carries 0x3F00FF8000FF.
- CMD55 0x770000000065 with one CRC bit flipped → ocrc_err pulse, no ocmd_valid, no drive; with SD_CMD_STATS_EN ocrc_err_count=1.
- Valid command, iresp_valid never asserted → otimeout at E+64, IDLE; iresp_valid at E+65 is ignored.
- irst low mid-TX → ocmd_sd_en=0 immediately; after release, next CMD0 is received normally.
